// File: rtl/fios_result_reducer.sv
// rtl/fios_result_reducer.sv - collects FIOS result limbs and applies the final conditional subtraction
// Limb-serial R - P is formed while limbs arrive; R or D is selected once the top limb borrow is known.
module fios_result_reducer #(
   parameter int S      = 8,
   parameter int LIMB_W = 17
) (
   input  logic              clock_i,
   input  logic              reset_i,
   input  logic              p_load_i,
   input  logic [LIMB_W-1:0] p_i,
   output logic              p_loaded_o,
   input  logic              res_valid_i,
   input  logic [LIMB_W-1:0] res_i,
   output logic              in_ready_o,
   output logic              out_valid_o,
   output logic [LIMB_W-1:0] out_data_o,
   output logic              out_last_o,
   input  logic              out_ready_i,
   output logic              error_o
);

   localparam int CW = $clog2(S + 1);
   localparam int IW = (S > 1) ? $clog2(S) : 1;

   typedef enum logic {COLLECT, EMIT} state_t;

   state_t            state_q, state_d;
   logic [LIMB_W-1:0] p_mem [S];
   logic [LIMB_W-1:0] r_buf [S];
   logic [LIMB_W-1:0] d_buf [S];
   logic [CW-1:0]     col_cnt_q, col_cnt_d;
   logic [IW-1:0]     load_cnt_q, load_cnt_d;
   logic [IW-1:0]     emit_cnt_q, emit_cnt_d;
   logic [IW-1:0]     p_idx, col_idx;
   logic              borrow_q, borrow_d;
   logic              sel_d_q, sel_d_d;
   logic              p_loaded_q, p_loaded_d;
   logic              error_q, error_d;
   logic              p_legal, p_wr, r_wr, col_top;
   logic [LIMB_W:0]   diff, top;

   assign in_ready_o  = (state_q == COLLECT) && p_loaded_q;
   assign p_loaded_o  = p_loaded_q;
   assign error_o     = error_q;
   assign out_valid_o = (state_q == EMIT);
   assign out_last_o  = (state_q == EMIT) && (emit_cnt_q == IW'(S - 1));
   assign out_data_o  = (state_q != EMIT) ? '0 :
                        (sel_d_q ? d_buf[emit_cnt_q] : r_buf[emit_cnt_q]);

   assign col_idx = col_cnt_q[IW-1:0];
   assign col_top = (col_cnt_q == CW'(S));

   always_comb begin
      state_d    = state_q;
      col_cnt_d  = col_cnt_q;
      load_cnt_d = load_cnt_q;
      emit_cnt_d = emit_cnt_q;
      borrow_d   = borrow_q;
      sel_d_d    = sel_d_q;
      p_loaded_d = p_loaded_q;
      error_d    = error_q;

      p_legal = (state_q == COLLECT) && (col_cnt_q == '0);
      p_wr    = p_load_i && p_legal && !reset_i;
      r_wr    = res_valid_i && in_ready_o && !p_wr && !reset_i;
      p_idx   = p_loaded_q ? '0 : load_cnt_q;
      diff    = {1'b0, res_i} - {1'b0, p_mem[col_idx]} - {{LIMB_W{1'b0}}, borrow_q};
      top     = {1'b0, res_i} - {{LIMB_W{1'b0}}, borrow_q};

      if ((p_load_i && !p_legal) || (res_valid_i && !in_ready_o) || (p_load_i && res_valid_i))
         error_d = 1'b1;

      // A load after completion restarts at limb 0 and invalidates the stored modulus.
      if (p_wr) begin
         if (p_idx == IW'(S - 1)) begin
            load_cnt_d = '0;
            p_loaded_d = 1'b1;
         end else begin
            load_cnt_d = p_idx + IW'(1);
            p_loaded_d = 1'b0;
         end
      end

      if (r_wr) begin
         if (col_top) begin
            sel_d_d   = !top[LIMB_W];
            state_d   = EMIT;
            col_cnt_d = '0;
            borrow_d  = 1'b0;
         end else begin
            borrow_d  = diff[LIMB_W];
            col_cnt_d = col_cnt_q + CW'(1);
         end
      end

      if (state_q == EMIT && out_ready_i) begin
         if (emit_cnt_q == IW'(S - 1)) begin
            emit_cnt_d = '0;
            col_cnt_d  = '0;
            borrow_d   = 1'b0;
            state_d    = COLLECT;
         end else begin
            emit_cnt_d = emit_cnt_q + IW'(1);
         end
      end
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q    <= COLLECT;
         col_cnt_q  <= '0;
         load_cnt_q <= '0;
         emit_cnt_q <= '0;
         borrow_q   <= 1'b0;
         sel_d_q    <= 1'b0;
         p_loaded_q <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         col_cnt_q  <= col_cnt_d;
         load_cnt_q <= load_cnt_d;
         emit_cnt_q <= emit_cnt_d;
         borrow_q   <= borrow_d;
         sel_d_q    <= sel_d_d;
         p_loaded_q <= p_loaded_d;
         error_q    <= error_d;
      end
   end

   // Limb storage is not reset; p_loaded_o gates its use.
   always_ff @(posedge clock_i) begin
      if (p_wr)
         p_mem[p_idx] <= p_i;
      if (r_wr && !col_top) begin
         r_buf[col_idx] <= res_i;
         d_buf[col_idx] <= diff[LIMB_W-1:0];
      end
   end

endmodule

// File: doc/fios_result_reducer.md
# fios_result_reducer

Final-stage consumer for the FIOS Montgomery multiplier's cascaded PE chain. It collects the radix-2^17 result limbs that the last PE emits (least-significant limb first) and performs the Montgomery final conditional subtraction (R ≥ P ? R − P : R) limb-serially. It then returns the reduced S-limb result through a valid/ready stream. It holds one result at a time and stores the modulus P locally, loaded once per key.

## Interface
- S, 8, number of 17-bit limbs in P and in the reduced output; the chain delivers S+1 result limbs.
- LIMB_W, 17, limb width; fixed at 17 by the DSP datapath, and any other value is unsupported.
- clock_i  in  1  clock; all state is updated on the rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- p_load_i  in  1  P limb valid.
- p_i  in  17  P limb, LSB limb first, S limbs.
- p_loaded_o  out  1  high once all S P limbs are stored.
- res_valid_i  in  1  result limb valid, driven from the last PE's RES_o.
- res_i  in  17  result limb, LSB limb first, S+1 limbs per result.
- in_ready_o  out  1  block can accept a result limb this cycle.
- out_valid_o  out  1  reduced limb valid.
- out_data_o  out  17  reduced limb, LSB limb first.
- out_last_o  out  1  marks limb S−1.
- out_ready_i  in  1  downstream accepts the limb.
- error_o  out  1  sticky protocol-error flag.

## Operation
- Storage:
  - P memory: S×17 bits.
  - R buffer and D buffer: S×17 bits each.
  - Borrow bit, top limb R_S, load counter, collect counter (0..S) and emit counter (0..S−1).
- State COLLECT (the reset state):
  - in_ready_o = p_loaded_o.
  - On each accepted limb k (k < S), the block stores R[k] = res_i.
  - On the same accept it stores D[k] = (res_i − P[k] − borrow) mod 2^17 and sets borrow = (res_i < P[k] + borrow).
  - Limb S: the block computes top = res_i − borrow, using 18-bit arithmetic. The final borrow_out is 1 when res_i < borrow. Then the state changes to EMIT.
  - Selection: sel_D = !borrow_out, i.e. R ≥ P. The selection is latched at the EMIT transition.
- State EMIT:
  - out_valid_o = 1.
  - out_data_o = sel_D ? D[e] : R[e], where e is the emit counter.
  - out_last_o = (e == S−1).
  - e increments on each out_valid_o && out_ready_i.
  - After the handshake on e = S−1, the block clears the counters and the borrow, and returns to COLLECT.
- P load:
  - Accepted only in COLLECT while the collect counter is 0.
  - Each p_load_i stores one limb at the load counter.
  - p_loaded_o rises after limb S−1 is stored.
  - A further p_load_i after completion restarts the load at limb 0 and clears p_loaded_o.
- error_o is set, and stays set until reset, on any of these events:
  - res_valid_i while in_ready_o = 0. The limb is dropped.
  - p_load_i while a collection or emission is in progress. The limb is dropped.
  - p_load_i and res_valid_i in the same cycle. p_load_i wins when it is legal, and the result limb is dropped.
- Reset values:
  - State = COLLECT; all counters, the borrow and sel_D = 0.
  - out_valid_o = 0, out_last_o = 0, out_data_o = 0.
  - in_ready_o = 0, p_loaded_o = 0, error_o = 0.
  - P contents are not cleared, but p_loaded_o = 0 forces a reload.

## Timing
- Result limb capture: a limb is captured on the edge where res_valid_i && in_ready_o. The chain may present limbs back-to-back, one per cycle, with no bubbles required.
- EMIT entry: out_valid_o rises in the first cycle after limb S is accepted, with limb 0 valid. The latency from the last input limb to the first output limb is 1 cycle.
- Output throughput: one limb per cycle while out_ready_i = 1.
- Backpressure: out_data_o, out_last_o and out_valid_o hold stable while out_ready_i = 0.
- Return to COLLECT: in_ready_o rises in the cycle after the out_last_o handshake. The minimum period is 2S+1 cycles per result.
- Reset mid-operation: reset asserted at any point aborts the current result. All outputs take their reset values asynchronously. No partial output is ever emitted after reset.
- Output register width: out_data_o is a full 17 bits; no carry beyond limb S−1 is ever output, because the reduced result is < P.

## Test plan
- Load P = {5, 0} with S = 2, then stream R = {7, 0, 0}:
  - Required: p_loaded_o rises after 2 loads, output is {2, 0} with out_last_o on the 2nd limb, and the first out_valid_o is 1 cycle after the 3rd input limb.
- With P = {5, 0}, stream R = {3, 0, 0}:
  - Required: borrow_out = 1 and the output is {3, 0} unchanged.
- With P = {0x00001, 0x00001}, stream R = {0x1FFFF, 0x00001, 0}:
  - Required: the output is {0x1FFFE, 0x00000}.
- Equality and top-limb case:
  - R = P = {0x0ABCD, 0x1FFFF} with top limb 0 must give output {0, 0}.
  - R = {0, 0, 1} with P = {1, 0} must give output {0x1FFFF, 0x1FFFF}.
- Backpressure:
  - Hold out_ready_i = 0 for 5 cycles during EMIT. Required: the data is held stable and in_ready_o stays 0.
  - Drive res_valid_i during EMIT. Required: error_o = 1 and the output is unchanged.
- Reset:
  - Assert reset_i after 1 of 3 limbs, asynchronously mid-cycle. Required: all outputs are 0 immediately and p_loaded_o = 0.
  - After reloading P, a full result must reduce correctly.
